button_event: RTL and testbench

Converts the clean, debounced level from the push-button debouncer into discrete user events: a press pulse, a release pulse, a long-press pulse, and periodic auto-repeat pulses while the button stays held. It sits directly downstream of the debouncer and upstream of the control and menu logic, which consumes only single-cycle strobes. It also keeps a wrapping count of presses for status display.

---
 rtl/button_event_pkg.sv | 15 +
 rtl/button_event_if.sv | 20 ++
 rtl/dffr_ns.sv | 16 +
 rtl/event_timer.sv | 31 +++
 rtl/button_event.sv | 117 +++++++++++
 tb/tb_button_event.sv | 218 +++++++++++++++++++++
 6 files changed

// File: rtl/button_event_pkg.sv
// rtl/button_event_pkg.sv - state encoding and default thresholds for button_event
package button_event_pkg;

  typedef enum logic [1:0] {
    ST_DISARMED = 2'b00,
    ST_IDLE     = 2'b01,
    ST_PRESSED  = 2'b11,
    ST_LONG     = 2'b10
  } state_e;

  localparam int unsigned DEF_CNT_WIDTH     = 24;
  localparam logic [23:0] DEF_LONG_CYCLES   = 24'd10_000_000;
  localparam logic [23:0] DEF_REPEAT_CYCLES = 24'd2_500_000;

endpackage

// File: rtl/button_event_if.sv
// rtl/button_event_if.sv - debounced level in, event strobes and status out
interface button_event_if;
  logic       in_lvl;
  logic       press;
  logic       rel;
  logic       long_press;
  logic       rpt;
  logic       held;
  logic [7:0] press_count;

  modport master (
    output in_lvl,
    input  press, rel, long_press, rpt, held, press_count
  );

  modport slave (
    input  in_lvl,
    output press, rel, long_press, rpt, held, press_count
  );
endinterface

// File: rtl/dffr_ns.sv
// rtl/dffr_ns.sv - plain register with synchronous active-low clear to zero
module dffr_ns #(
  parameter int unsigned W = 1
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  always_ff @(posedge clk_i) begin
    if (!reset_i) q_o <= '0;
    else          q_o <= d_i;
  end

endmodule

// File: rtl/event_timer.sv
// rtl/event_timer.sv - hold/repeat timer with clear, enable and equality hit
module event_timer #(
  parameter int unsigned CNT_WIDTH = 24
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 clr_i,
  input  logic                 en_i,
  input  logic [CNT_WIDTH-1:0] match_val_i,
  output logic                 hit_o
);

  logic [CNT_WIDTH-1:0] count_q, count_d;

  // Clear dominates enable so the FSM can restart timing on the same edge it leaves a state.
  always_comb begin
    count_d = count_q;
    if (clr_i)     count_d = '0;
    else if (en_i) count_d = count_q + CNT_WIDTH'(1);
  end

  dffr_ns #(.W(CNT_WIDTH)) u_count (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .d_i     (count_d),
    .q_o     (count_q)
  );

  assign hit_o = (count_q == match_val_i);

endmodule

// File: rtl/button_event.sv
// rtl/button_event.sv - turns a debounced button level into press/release/long/repeat strobes
module button_event
  import button_event_pkg::*;
#(
  parameter int unsigned          CNT_WIDTH     = DEF_CNT_WIDTH,
  parameter logic [CNT_WIDTH-1:0] LONG_CYCLES   = CNT_WIDTH'(DEF_LONG_CYCLES),
  parameter logic [CNT_WIDTH-1:0] REPEAT_CYCLES = CNT_WIDTH'(DEF_REPEAT_CYCLES),
  parameter bit                   REPEAT_EN     = 1'b1
) (
  input  logic           clk_i,
  input  logic           reset_i,
  button_event_if.slave  bus
);

  localparam logic [CNT_WIDTH-1:0] ONE     = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] LONG_M1 = LONG_CYCLES - ONE;
  localparam logic [CNT_WIDTH-1:0] REP_M1  = REPEAT_CYCLES - ONE;

  state_e     state_q, state_d;
  logic       press_q, press_d;
  logic       rel_q, rel_d;
  logic       long_q, long_d;
  logic       rpt_q, rpt_d;
  logic       held_q, held_d;
  logic [7:0] count_q, count_d;

  logic                 tmr_clr, tmr_en, tmr_hit;
  logic [CNT_WIDTH-1:0] match_val;

  assign match_val = (state_q == ST_PRESSED) ? LONG_M1 : REP_M1;

  event_timer #(.CNT_WIDTH(CNT_WIDTH)) u_timer (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .clr_i       (tmr_clr),
    .en_i        (tmr_en),
    .match_val_i (match_val),
    .hit_o       (tmr_hit)
  );

  // Timer is cleared by default; only active hold phases let it count.
  always_comb begin
    state_d = state_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    long_d  = 1'b0;
    rpt_d   = 1'b0;
    count_d = count_q;
    tmr_clr = 1'b1;
    tmr_en  = 1'b0;
    case (state_q)
      ST_DISARMED: begin
        if (!bus.in_lvl) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (bus.in_lvl) begin
          state_d = ST_PRESSED;
          press_d = 1'b1;
          count_d = count_q + 8'd1;
        end
      end
      ST_PRESSED: begin
        if (!bus.in_lvl) begin
          state_d = ST_IDLE;
          rel_d   = 1'b1;
        end else if (tmr_hit) begin
          state_d = ST_LONG;
          long_d  = 1'b1;
        end else begin
          tmr_clr = 1'b0;
          tmr_en  = 1'b1;
        end
      end
      ST_LONG: begin
        if (!bus.in_lvl) begin
          state_d = ST_IDLE;
          rel_d   = 1'b1;
        end else if (REPEAT_EN && tmr_hit) begin
          rpt_d = 1'b1;
        end else if (REPEAT_EN) begin
          tmr_clr = 1'b0;
          tmr_en  = 1'b1;
        end
      end
      default: state_d = ST_DISARMED;
    endcase
    held_d = (state_d == ST_PRESSED) || (state_d == ST_LONG);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q <= ST_DISARMED;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      long_q  <= 1'b0;
      rpt_q   <= 1'b0;
      held_q  <= 1'b0;
      count_q <= 8'd0;
    end else begin
      state_q <= state_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      long_q  <= long_d;
      rpt_q   <= rpt_d;
      held_q  <= held_d;
      count_q <= count_d;
    end
  end

  assign bus.press       = press_q;
  assign bus.rel         = rel_q;
  assign bus.long_press  = long_q;
  assign bus.rpt         = rpt_q;
  assign bus.held        = held_q;
  assign bus.press_count = count_q;

endmodule

// File: tb/tb_button_event.sv
// tb/tb_button_event.sv - scoreboard bench for button_event with repeat enabled and disabled
module tb_button_event;

  localparam int LONG = 8;
  localparam int REP  = 4;

  typedef struct {
    int         cyc;
    logic [3:0] kind;
  } ev_t;

  typedef struct {
    int         cyc;
    logic       held;
    logic [7:0] cnt;
  } lvl_t;

  logic clk = 1'b0;
  logic rst_n;
  logic btn;

  always #5 clk = ~clk;

  button_event_if bus0 ();
  button_event_if bus1 ();

  assign bus0.in_lvl = btn;
  assign bus1.in_lvl = btn;

  button_event #(
    .CNT_WIDTH     (24),
    .LONG_CYCLES   (24'd8),
    .REPEAT_CYCLES (24'd4),
    .REPEAT_EN     (1'b1)
  ) dut0 (
    .clk_i   (clk),
    .reset_i (rst_n),
    .bus     (bus0.slave)
  );

  button_event #(
    .CNT_WIDTH     (24),
    .LONG_CYCLES   (24'd8),
    .REPEAT_CYCLES (24'd4),
    .REPEAT_EN     (1'b0)
  ) dut1 (
    .clk_i   (clk),
    .reset_i (rst_n),
    .bus     (bus1.slave)
  );

  ev_t  ev0_q[$];
  ev_t  ev1_q[$];
  lvl_t lvl_q[$];

  int edge_cnt    = 0;
  int vectors     = 0;
  int miscompares = 0;

  // Reference model: armed/pressed flags plus the number of held edges since the press.
  bit armed   = 1'b0;
  bit pressed = 1'b0;
  int hold    = 0;
  int cnt_m   = 0;

  task automatic drive(input logic r, input logic i);
    ev_t  e;
    lvl_t l;
    int   n;
    rst_n  = r;
    btn    = i;
    n      = edge_cnt + 1;
    e.cyc  = n;
    e.kind = 4'b0000;
    if (!r) begin
      armed   = 1'b0;
      pressed = 1'b0;
      hold    = 0;
      cnt_m   = 0;
    end else if (!armed) begin
      if (!i) armed = 1'b1;
    end else if (!pressed) begin
      if (i) begin
        pressed = 1'b1;
        hold    = 0;
        cnt_m   = (cnt_m + 1) % 256;
        e.kind  = 4'b0001;
      end
    end else if (!i) begin
      pressed = 1'b0;
      e.kind  = 4'b0010;
    end else begin
      hold = hold + 1;
      if (hold == LONG) e.kind = 4'b0100;
      else if (hold > LONG && ((hold - LONG) % REP) == 0) e.kind = 4'b1000;
    end
    if (e.kind != 4'b0000) begin
      ev0_q.push_back(e);
      if (e.kind != 4'b1000) ev1_q.push_back(e);
    end
    l.cyc  = n;
    l.held = pressed;
    l.cnt  = 8'(cnt_m);
    lvl_q.push_back(l);
    @(negedge clk);
  endtask

  task automatic hold_lvl(input logic r, input logic i, input int n);
    for (int k = 0; k < n; k++) drive(r, i);
  endtask

  function automatic void pop_ev(input int id);
    if (id == 0) void'(ev0_q.pop_front());
    else         void'(ev1_q.pop_front());
  endfunction

  task automatic check_dut(input int id, input logic [3:0] s);
    ev_t e;
    bit  have;
    while (1) begin
      have = 1'b0;
      if (id == 0 && ev0_q.size() > 0) begin e = ev0_q[0]; have = 1'b1; end
      if (id == 1 && ev1_q.size() > 0) begin e = ev1_q[0]; have = 1'b1; end
      if (!have || e.cyc >= edge_cnt) break;
      vectors++;
      miscompares++;
      $display("FAIL missed_event dut%0d cyc %0d: got strobes 0000 expected %b", id, e.cyc, e.kind);
      pop_ev(id);
    end
    if (have && e.cyc == edge_cnt) begin
      vectors++;
      if (s !== e.kind) begin
        miscompares++;
        $display("FAIL strobes dut%0d cyc %0d: got %b expected %b", id, edge_cnt, s, e.kind);
      end
      pop_ev(id);
    end else if (s !== 4'b0000) begin
      vectors++;
      miscompares++;
      $display("FAIL spurious_strobe dut%0d cyc %0d: got %b expected 0000", id, edge_cnt, s);
    end
  endtask

  task automatic check_lvl(input int id, input logic h, input logic [7:0] c, input lvl_t l);
    vectors++;
    if (h !== l.held || c !== l.cnt) begin
      miscompares++;
      $display("FAIL level dut%0d cyc %0d: got held=%b count=%0d expected held=%b count=%0d",
               id, edge_cnt, h, c, l.held, l.cnt);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      edge_cnt++;
      #1;
      check_dut(0, {bus0.rpt, bus0.long_press, bus0.rel, bus0.press});
      check_dut(1, {bus1.rpt, bus1.long_press, bus1.rel, bus1.press});
      while (lvl_q.size() > 0 && lvl_q[0].cyc < edge_cnt) void'(lvl_q.pop_front());
      if (lvl_q.size() > 0 && lvl_q[0].cyc == edge_cnt) begin
        check_lvl(0, bus0.held, bus0.press_count, lvl_q[0]);
        check_lvl(1, bus1.held, bus1.press_count, lvl_q[0]);
        void'(lvl_q.pop_front());
      end
    end
  end

  int   len;
  logic lv;
  logic rr;

  initial begin
    hold_lvl(1'b0, 1'b0, 3);
    hold_lvl(1'b1, 1'b0, 3);
    // short press, long hold with repeats, release on the long threshold edge
    hold_lvl(1'b1, 1'b1, 3);
    hold_lvl(1'b1, 1'b0, 4);
    hold_lvl(1'b1, 1'b1, 21);
    hold_lvl(1'b1, 1'b0, 4);
    hold_lvl(1'b1, 1'b1, 8);
    hold_lvl(1'b1, 1'b0, 4);
    // held through reset, then a fresh press
    hold_lvl(1'b0, 1'b1, 2);
    hold_lvl(1'b1, 1'b1, 10);
    hold_lvl(1'b1, 1'b0, 3);
    hold_lvl(1'b1, 1'b1, 3);
    hold_lvl(1'b1, 1'b0, 3);
    // reset in the middle of a long hold
    hold_lvl(1'b1, 1'b1, 12);
    hold_lvl(1'b0, 1'b1, 1);
    hold_lvl(1'b1, 1'b0, 3);
    for (int k = 0; k < 150; k++) begin
      len = $urandom_range(1, 26);
      lv  = 1'($urandom_range(0, 1));
      rr  = ($urandom_range(0, 29) != 0);
      if (!rr) len = $urandom_range(1, 3);
      hold_lvl(rr, lv, len);
    end
    // press counter wrap, then a long hold
    hold_lvl(1'b0, 1'b0, 2);
    hold_lvl(1'b1, 1'b0, 1);
    for (int k = 0; k < 256; k++) begin
      hold_lvl(1'b1, 1'b1, 2);
      hold_lvl(1'b1, 1'b0, 2);
    end
    hold_lvl(1'b1, 1'b1, 22);
    hold_lvl(1'b1, 1'b0, 5);
    vectors++;
    if (ev0_q.size() != 0 || ev1_q.size() != 0) begin
      miscompares++;
      $display("FAIL pending_events: got %0d/%0d left expected 0/0", ev0_q.size(), ev1_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
